// File: rtl/cpu_defs.sv
// Shared execute-stage types used by the long-latency operation sequencer.
package cpu_defs;

    typedef enum logic [1:0] {
        MulLo  = 2'd0,
        MulHi  = 2'd1,
        MulHiu = 2'd2
    } mul_op_t;

    typedef enum logic [1:0] {
        DivQ  = 2'd0,
        DivR  = 2'd1,
        DivQu = 2'd2,
        DivRu = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        StIdle,
        StMulRun,
        StDivRun,
        StDone
    } lop_state_t;

    function automatic logic mul_is_signed(mul_op_t op);
        return op != MulHiu;
    endfunction

    function automatic logic div_is_signed(div_op_t op);
        return (op == DivQ) || (op == DivR);
    endfunction

    function automatic logic div_wants_rem(div_op_t op);
        return (op == DivR) || (op == DivRu);
    endfunction

endpackage

// File: rtl/div_special.sv
// Detects divisions whose result is fixed (divide by zero, signed INT_MIN / -1)
// and supplies that result so the iterative divider need not be launched.
module div_special #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              is_signed_i,
    output logic              special_o,
    output logic [DATA_W-1:0] q_o,
    output logic [DATA_W-1:0] r_o
);

    logic [DATA_W-1:0] int_min;
    assign int_min = {1'b1, {(DATA_W - 1){1'b0}}};

    // Classify the operand pair and produce the architecturally fixed result.
    always_comb begin
        special_o = 1'b0;
        q_o       = '0;
        r_o       = '0;
        if (b_i == '0) begin
            special_o = 1'b1;
            q_o       = '1;
            r_o       = a_i;
        end else if (is_signed_i && (a_i == int_min) && (b_i == '1)) begin
            special_o = 1'b1;
            q_o       = int_min;
            r_o       = '0;
        end
    end

endmodule

// File: rtl/longop_sched.sv
// Sequencer for the execute stage's multiplier and iterative divider: latches
// operands, launches one unit operation per instruction, stalls EX until the
// result is ready and holds it while the downstream stage stalls.
module longop_sched
    import cpu_defs::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter bit          FAST_DIV = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                stall_i,
    input  logic                req_valid,
    input  logic                req_is_div,
    input  logic [1:0]          req_mul_op,
    input  logic [1:0]          req_div_op,
    input  logic [DATA_W-1:0]   req_a,
    input  logic [DATA_W-1:0]   req_b,
    output logic                mul_start,
    output logic                mul_signed,
    output logic                mul_abort,
    input  logic                mul_done_i,
    input  logic [2*DATA_W-1:0] mul_out_i,
    output logic                div_start,
    output logic                div_signed,
    output logic                div_abort,
    input  logic                div_done_i,
    input  logic [DATA_W-1:0]   div_q_i,
    input  logic [DATA_W-1:0]   div_r_i,
    output logic [DATA_W-1:0]   op_a,
    output logic [DATA_W-1:0]   op_b,
    output logic                eu_stall,
    output logic                res_valid,
    output logic [DATA_W-1:0]   result
);

    lop_state_t        state_q, state_d;
    mul_op_t           mul_op_q, mul_op_d;
    div_op_t           div_op_q, div_op_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              mul_signed_q, mul_signed_d, div_signed_q, div_signed_d;
    logic              mul_start_q, mul_start_d, div_start_q, div_start_d;

    mul_op_t           req_mul_op_e;
    div_op_t           req_div_op_e;
    logic              spec_hit;
    logic [DATA_W-1:0] spec_q, spec_r;

    assign req_mul_op_e = mul_op_t'(req_mul_op);
    assign req_div_op_e = div_op_t'(req_div_op);

    // Special cases are judged on the live request so they resolve in the request cycle.
    div_special #(
        .DATA_W (DATA_W)
    ) u_div_special (
        .a_i         (req_a),
        .b_i         (req_b),
        .is_signed_i (div_is_signed(req_div_op_e)),
        .special_o   (spec_hit),
        .q_o         (spec_q),
        .r_o         (spec_r)
    );

    // Next-state, operand latching, launch pulses and result capture; flush overrides all.
    always_comb begin
        state_d      = state_q;
        mul_op_d     = mul_op_q;
        div_op_d     = div_op_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        result_d     = result_q;
        mul_signed_d = mul_signed_q;
        div_signed_d = div_signed_q;
        mul_start_d  = 1'b0;
        div_start_d  = 1'b0;
        if (flush_i) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        op_a_d = req_a;
                        op_b_d = req_b;
                        if (!req_is_div) begin
                            mul_op_d     = req_mul_op_e;
                            mul_signed_d = mul_is_signed(req_mul_op_e);
                            mul_start_d  = 1'b1;
                            state_d      = StMulRun;
                        end else begin
                            div_op_d     = req_div_op_e;
                            div_signed_d = div_is_signed(req_div_op_e);
                            if (FAST_DIV && spec_hit) begin
                                result_d = div_wants_rem(req_div_op_e) ? spec_r : spec_q;
                                state_d  = StDone;
                            end else begin
                                div_start_d = 1'b1;
                                state_d     = StDivRun;
                            end
                        end
                    end
                end
                StMulRun: begin
                    if (mul_done_i) begin
                        result_d = (mul_op_q == MulLo) ? mul_out_i[DATA_W-1:0]
                                                       : mul_out_i[2*DATA_W-1:DATA_W];
                        state_d  = StDone;
                    end
                end
                StDivRun: begin
                    if (div_done_i) begin
                        result_d = div_wants_rem(div_op_q) ? div_r_i : div_q_i;
                        state_d  = StDone;
                    end
                end
                StDone: begin
                    // Held instruction never relaunches; leave only once it advances.
                    if (!stall_i) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            mul_op_q     <= MulLo;
            div_op_q     <= DivQ;
            op_a_q       <= '0;
            op_b_q       <= '0;
            result_q     <= '0;
            mul_signed_q <= 1'b0;
            div_signed_q <= 1'b0;
            mul_start_q  <= 1'b0;
            div_start_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            mul_op_q     <= mul_op_d;
            div_op_q     <= div_op_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            result_q     <= result_d;
            mul_signed_q <= mul_signed_d;
            div_signed_q <= div_signed_d;
            mul_start_q  <= mul_start_d;
            div_start_q  <= div_start_d;
        end
    end

    // Output drive; aborts only for the unit actually running and never during reset.
    always_comb begin
        mul_start  = mul_start_q;
        div_start  = div_start_q;
        mul_signed = mul_signed_q;
        div_signed = div_signed_q;
        op_a       = op_a_q;
        op_b       = op_b_q;
        result     = result_q;
        mul_abort  = rst_n & flush_i & (state_q == StMulRun);
        div_abort  = rst_n & flush_i & (state_q == StDivRun);
        eu_stall   = req_valid & (state_q != StDone);
        res_valid  = rst_n & ~flush_i & (state_q == StDone);
    end

endmodule

// File: tb/tb_longop_sched.sv
// Self-checking bench for longop_sched with behavioural multiplier/divider models.
module tb_longop_sched;
    import cpu_defs::*;

    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           rst_n, flush_i, stall_i, req_valid, req_is_div;
    logic [1:0]     req_mul_op, req_div_op;
    logic [W-1:0]   req_a, req_b;
    logic           mul_start, mul_signed, mul_abort, mul_done_i;
    logic [2*W-1:0] mul_out_i;
    logic           div_start, div_signed, div_abort, div_done_i;
    logic [W-1:0]   div_q_i, div_r_i, op_a, op_b, result;
    logic           eu_stall, res_valid;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] exp_q[$];

    int             mul_lat = 2;
    int             div_lat = 4;
    int             mul_cnt = 0;
    int             div_cnt = 0;
    logic [2*W-1:0] mul_res_m = '0;
    logic [W-1:0]   div_q_m = '0;
    logic [W-1:0]   div_r_m = '0;
    logic           stray_mul_done = 1'b0;
    logic           stray_div_done = 1'b0;

    longop_sched #(.DATA_W(W), .FAST_DIV(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush_i),
        .stall_i    (stall_i),
        .req_valid  (req_valid),
        .req_is_div (req_is_div),
        .req_mul_op (req_mul_op),
        .req_div_op (req_div_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .mul_start  (mul_start),
        .mul_signed (mul_signed),
        .mul_abort  (mul_abort),
        .mul_done_i (mul_done_i),
        .mul_out_i  (mul_out_i),
        .div_start  (div_start),
        .div_signed (div_signed),
        .div_abort  (div_abort),
        .div_done_i (div_done_i),
        .div_q_i    (div_q_i),
        .div_r_i    (div_r_i),
        .op_a       (op_a),
        .op_b       (op_b),
        .eu_stall   (eu_stall),
        .res_valid  (res_valid),
        .result     (result)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ext(input logic [W-1:0] v, input logic s);
        return s ? {{W{v[W-1]}}, v} : {{W{1'b0}}, v};
    endfunction

    // Multiplier model: done arrives mul_lat-1 cycles after the start cycle.
    always @(posedge clk) begin
        if (!rst_n || mul_abort) mul_cnt <= 0;
        else if (mul_start) begin
            mul_cnt   <= mul_lat - 1;
            mul_res_m <= ext(op_a, mul_signed) * ext(op_b, mul_signed);
        end else if (mul_cnt != 0) mul_cnt <= mul_cnt - 1;
    end
    assign mul_done_i = (mul_cnt == 1) || stray_mul_done;
    assign mul_out_i  = mul_res_m;

    // Divider model, same timing convention.
    always @(posedge clk) begin
        if (!rst_n || div_abort) div_cnt <= 0;
        else if (div_start) begin
            div_cnt <= div_lat - 1;
            if (op_b == '0) begin
                div_q_m <= '1;
                div_r_m <= op_a;
            end else if (div_signed) begin
                div_q_m <= $signed(op_a) / $signed(op_b);
                div_r_m <= $signed(op_a) % $signed(op_b);
            end else begin
                div_q_m <= op_a / op_b;
                div_r_m <= op_a % op_b;
            end
        end else if (div_cnt != 0) div_cnt <= div_cnt - 1;
    end
    assign div_done_i = (div_cnt == 1) || stray_div_done;
    assign div_q_i    = div_q_m;
    assign div_r_i    = div_r_m;

    task automatic issue(input logic is_div, input logic [1:0] mop, input logic [1:0] dop,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid  = 1'b1;
        req_is_div = is_div;
        req_mul_op = mop;
        req_div_op = dop;
        req_a      = a;
        req_b      = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush_i = 1'b0; stall_i = 1'b0; req_valid = 1'b0; req_is_div = 1'b0;
        req_mul_op = 2'd0; req_div_op = 2'd0; req_a = '0; req_b = '0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({mul_start, mul_signed, mul_abort, div_start, div_signed, div_abort, eu_stall,
             res_valid} !== 8'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000000", {mul_start, mul_signed,
                     mul_abort, div_start, div_signed, div_abort, eu_stall, res_valid});
        end
        checks++;
        if ({result, op_a, op_b} !== {3*W{1'b0}}) begin
            errors++;
            $display("FAIL reset_data: result=%h op_a=%h op_b=%h required 0", result, op_a, op_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Done pulses outside a run must be ignored.
        @(negedge clk);
        stray_mul_done = 1'b1; stray_div_done = 1'b1;
        @(negedge clk);
        stray_mul_done = 1'b0; stray_div_done = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL stray_done: res_valid=%b required 0", res_valid);
        end
    endtask

    task automatic test_mul_lo();
        int stalls, starts;
        bit got;
        logic [W-1:0] exp;
        stalls = 0; starts = 0; got = 0; mul_lat = 2;
        @(negedge clk);
        issue(1'b0, MulLo, DivQ, 32'd7, 32'hFFFF_FFFD);
        exp_q.push_back(32'hFFFF_FFEB);
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (eu_stall) stalls++;
            if (mul_start) starts++;
            if (res_valid) got = 1;
            else begin
                @(negedge clk);
                req_a = 32'hDEAD_BEEF; req_b = 32'h1234_5678;
            end
        end
        exp = exp_q.pop_front();
        checks++;
        if (!got) begin
            errors++; $display("FAIL mul_lo_timeout: res_valid=0 required 1");
        end
        checks++;
        if (result !== exp) begin
            errors++; $display("FAIL mul_lo_result: got %h required %h", result, exp);
        end
        checks++;
        if (stalls != 3) begin
            errors++; $display("FAIL mul_lo_stall_cycles: got %0d required 3", stalls);
        end
        checks++;
        if (op_a !== 32'd7) begin
            errors++; $display("FAIL mul_lo_latched_a: got %h required 7", op_a);
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (mul_start) starts++;
            @(negedge clk);
        end
        checks++;
        if (starts != 1) begin
            errors++; $display("FAIL mul_lo_starts: got %0d required 1", starts);
        end
    endtask

    task automatic test_div_stall();
        int starts;
        bit got;
        logic [W-1:0] exp;
        starts = 0; got = 0; div_lat = 5;
        @(negedge clk);
        stall_i = 1'b1;
        issue(1'b1, MulLo, DivQ, 32'hFFFF_FFF9, 32'd2);
        exp_q.push_back(32'hFFFF_FFFD);
        for (int i = 0; i < 30 && !got; i++) begin
            #1;
            if (div_start) starts++;
            if (res_valid) got = 1;
            else @(negedge clk);
        end
        exp = exp_q.pop_front();
        checks++;
        if (!got || result !== exp) begin
            errors++;
            $display("FAIL div_q_result: valid=%b got %h required %h", got, result, exp);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (div_start) starts++;
            checks++;
            if (res_valid !== 1'b1 || result !== exp || eu_stall !== 1'b0) begin
                errors++;
                $display("FAIL div_q_hold%0d: valid=%b stall=%b result=%h required 1 0 %h",
                         k, res_valid, eu_stall, result, exp);
            end
        end
        @(negedge clk);
        stall_i = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL div_q_release: res_valid=%b required 0", res_valid);
        end
        repeat (6) begin
            @(negedge clk);
            #1;
            if (div_start) starts++;
        end
        checks++;
        if (starts != 1) begin
            errors++; $display("FAIL div_q_starts: got %0d required 1", starts);
        end
    endtask

    task automatic test_div_special();
        logic [1:0]   ops  [4];
        logic [W-1:0] as   [4];
        logic [W-1:0] bs   [4];
        logic [W-1:0] exps [4];
        logic [W-1:0] exp;
        ops[0] = DivQ;  as[0] = 32'h8000_0000; bs[0] = 32'hFFFF_FFFF; exps[0] = 32'h8000_0000;
        ops[1] = DivR;  as[1] = 32'h8000_0000; bs[1] = 32'hFFFF_FFFF; exps[1] = 32'h0;
        ops[2] = DivQu; as[2] = 32'd7;         bs[2] = 32'd0;         exps[2] = 32'hFFFF_FFFF;
        ops[3] = DivR;  as[3] = 32'd5;         bs[3] = 32'd0;         exps[3] = 32'd5;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            issue(1'b1, MulLo, ops[t], as[t], bs[t]);
            exp_q.push_back(exps[t]);
            #1;
            checks++;
            if (eu_stall !== 1'b1) begin
                errors++; $display("FAIL special%0d_stall: got %b required 1", t, eu_stall);
            end
            @(negedge clk);
            #1;
            exp = exp_q.pop_front();
            checks++;
            if (res_valid !== 1'b1 || result !== exp || div_start !== 1'b0) begin
                errors++;
                $display("FAIL special%0d_result: valid=%b start=%b got %h required 1 0 %h",
                         t, res_valid, div_start, result, exp);
            end
            @(negedge clk);
            req_valid = 1'b0;
        end
    endtask

    task automatic test_flush_div();
        int early;
        early = 0; div_lat = 40;
        @(negedge clk);
        issue(1'b1, MulLo, DivQ, 32'd100, 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (res_valid) early++;
        end
        @(negedge clk);
        flush_i = 1'b1; req_valid = 1'b0;
        #1;
        checks++;
        if (div_abort !== 1'b1 || mul_abort !== 1'b0) begin
            errors++;
            $display("FAIL flush_abort: div_abort=%b mul_abort=%b required 1 0",
                     div_abort, mul_abort);
        end
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        checks++;
        if (div_abort !== 1'b0 || res_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: div_abort=%b res_valid=%b required 0 0",
                     div_abort, res_valid);
        end
        repeat (45) begin
            @(negedge clk);
            #1;
            if (res_valid) early++;
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL flush_no_result: res_valid seen %0d required 0", early);
        end
    endtask

    task automatic test_done_flush();
        bit seen;
        int late;
        seen = 0; late = 0; div_lat = 4;
        @(negedge clk);
        issue(1'b1, MulLo, DivQ, 32'd9, 32'd3);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (div_done_i) begin
                seen = 1; flush_i = 1'b1; req_valid = 1'b0;
            end
        end
        #1;
        checks++;
        if (!seen || div_abort !== 1'b1) begin
            errors++;
            $display("FAIL done_flush_abort: done_seen=%b div_abort=%b required 1 1",
                     seen, div_abort);
        end
        @(negedge clk);
        flush_i = 1'b0;
        repeat (4) begin
            #1;
            if (res_valid) late++;
            @(negedge clk);
        end
        checks++;
        if (late != 0 || result !== 32'd5) begin
            errors++;
            $display("FAIL done_flush_discard: valid_seen=%0d result=%h required 0 00000005",
                     late, result);
        end
    endtask

    task automatic test_back_to_back();
        int mstarts, dstarts;
        bit got;
        logic [W-1:0] exp;
        mstarts = 0; dstarts = 0; got = 0; mul_lat = 3; div_lat = 6;
        @(negedge clk);
        issue(1'b0, MulHiu, DivQ, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFE);
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (mul_start) mstarts++;
            if (res_valid) got = 1;
            else @(negedge clk);
        end
        exp = exp_q.pop_front();
        checks++;
        if (!got || result !== exp || mul_signed !== 1'b0) begin
            errors++;
            $display("FAIL mulhu_result: valid=%b signed=%b got %h required 1 0 %h",
                     got, mul_signed, result, exp);
        end
        got = 0;
        @(negedge clk);
        issue(1'b1, MulLo, DivQu, 32'd100, 32'd7);
        exp_q.push_back(32'd14);
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (mul_start) mstarts++;
            if (div_start) dstarts++;
            if (res_valid) got = 1;
            else @(negedge clk);
        end
        exp = exp_q.pop_front();
        checks++;
        if (!got || result !== exp || div_signed !== 1'b0) begin
            errors++;
            $display("FAIL divqu_result: valid=%b signed=%b got %h required 1 0 %h",
                     got, div_signed, result, exp);
        end
        checks++;
        if (mstarts != 1 || dstarts != 1) begin
            errors++;
            $display("FAIL b2b_starts: mul=%0d div=%0d required 1 1", mstarts, dstarts);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_mul_lo();
        test_div_stall();
        test_div_special();
        test_flush_div();
        test_done_flush();
        test_back_to_back();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL scoreboard_left: %0d entries required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
